eth_arp_ctrl: RTL and testbench

ARP control block for the Ethernet video link. It sits above the ARP receive/transmit pair and consumes their receive results (`arp_rx_done`, `arp_rx_type`, `src_mac`, `src_ip`). It answers every received ARP request with a reply and, on user request, resolves the peer's MAC with broadcast requests. Resolved peer addresses go into a single-entry cache that the UDP/video path reads.

---
 rtl/eth_arp_ctrl_if.sv | 43 ++++
 rtl/eth_arp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_eth_arp_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_arp_ctrl_if.sv
// ARP control handshake bundle: rx results and user/tx strobes in, tx command and peer cache out.
// resolve_fail is present only when ARP_RETRY_EN is defined.
interface eth_arp_ctrl_if;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        arp_req;
  logic        tx_done;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        peer_valid;
  logic [47:0] peer_mac;
  logic [31:0] peer_ip;
  logic        arp_busy;
`ifdef ARP_RETRY_EN
  logic        resolve_fail;

  modport master (
    output arp_rx_done, arp_rx_type, src_mac, src_ip, arp_req, tx_done,
    input  arp_tx_en, arp_tx_type, des_mac, des_ip,
    input  peer_valid, peer_mac, peer_ip, arp_busy, resolve_fail
  );
  modport slave (
    input  arp_rx_done, arp_rx_type, src_mac, src_ip, arp_req, tx_done,
    output arp_tx_en, arp_tx_type, des_mac, des_ip,
    output peer_valid, peer_mac, peer_ip, arp_busy, resolve_fail
  );
`else
  modport master (
    output arp_rx_done, arp_rx_type, src_mac, src_ip, arp_req, tx_done,
    input  arp_tx_en, arp_tx_type, des_mac, des_ip,
    input  peer_valid, peer_mac, peer_ip, arp_busy
  );
  modport slave (
    input  arp_rx_done, arp_rx_type, src_mac, src_ip, arp_req, tx_done,
    output arp_tx_en, arp_tx_type, des_mac, des_ip,
    output peer_valid, peer_mac, peer_ip, arp_busy
  );
`endif
endinterface

// File: rtl/eth_arp_ctrl.sv
// ARP control: answers received requests, resolves DES_IP with broadcast requests, caches the peer.
// Optional macro ARP_RETRY_EN adds request retransmission and the resolve_fail pulse.
module eth_arp_ctrl #(
  parameter logic [31:0] DES_IP      = {8'd192, 8'd168, 8'd1, 8'd102},
  parameter int          TIMEOUT_CYC = 125_000_000,
  parameter int          RETRY_MAX   = 3
) (
  input  logic          clk,
  input  logic          rst,
  eth_arp_ctrl_if.slave arp
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_WAIT_REPLY} state_t;

  state_t      r_state;
  logic        r_reply_pend;
  logic        r_req_pend;
  logic        r_resolving;
  logic [47:0] r_rep_mac;
  logic [31:0] r_rep_ip;
  logic [31:0] r_timer;
  logic        r_arp_tx_en;
  logic        r_arp_tx_type;
  logic [47:0] r_des_mac;
  logic [31:0] r_des_ip;
  logic        r_peer_valid;
  logic [47:0] r_peer_mac;
  logic [31:0] r_peer_ip;
`ifdef ARP_RETRY_EN
  logic [31:0] r_retry_cnt;
  logic        r_resolve_fail;
`endif

  logic        w_req_rx;
  logic        w_peer_match;
  logic [47:0] w_rep_mac;
  logic [31:0] w_rep_ip;

  assign w_req_rx     = arp.arp_rx_done && !arp.arp_rx_type;
  assign w_peer_match = arp.arp_rx_done && arp.arp_rx_type && (arp.src_ip == DES_IP);
  // A request landing in the same cycle as a reply launch is the newest one, so use it directly.
  assign w_rep_mac    = w_req_rx ? arp.src_mac : r_rep_mac;
  assign w_rep_ip     = w_req_rx ? arp.src_ip  : r_rep_ip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_reply_pend  <= 1'b0;
      r_req_pend    <= 1'b0;
      r_resolving   <= 1'b0;
      r_rep_mac     <= '0;
      r_rep_ip      <= '0;
      r_timer       <= '0;
      r_arp_tx_en   <= 1'b0;
      r_arp_tx_type <= 1'b0;
      r_des_mac     <= '0;
      r_des_ip      <= '0;
      r_peer_valid  <= 1'b0;
      r_peer_mac    <= '0;
      r_peer_ip     <= '0;
`ifdef ARP_RETRY_EN
      r_retry_cnt    <= '0;
      r_resolve_fail <= 1'b0;
`endif
    end else begin
      r_arp_tx_en <= 1'b0;
`ifdef ARP_RETRY_EN
      r_resolve_fail <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_reply_pend) begin
            r_state       <= S_SEND;
            r_arp_tx_en   <= 1'b1;
            r_arp_tx_type <= 1'b1;
            r_des_mac     <= w_rep_mac;
            r_des_ip      <= w_rep_ip;
          end else if (r_req_pend) begin
            r_state       <= S_SEND;
            r_arp_tx_en   <= 1'b1;
            r_arp_tx_type <= 1'b0;
            r_des_mac     <= '1;
            r_des_ip      <= DES_IP;
            r_resolving   <= 1'b1;
            r_req_pend    <= 1'b0;
`ifdef ARP_RETRY_EN
            r_retry_cnt   <= '0;
`endif
          end
        end
        S_SEND: begin
          r_state <= S_WAIT_DONE;
          if (r_arp_tx_type) r_reply_pend <= 1'b0;
        end
        S_WAIT_DONE: begin
          if (arp.tx_done) begin
            if (!r_arp_tx_type) begin
              r_state <= S_WAIT_REPLY;
              r_timer <= '0;
            end else begin
              r_state <= r_resolving ? S_WAIT_REPLY : S_IDLE;
            end
          end
        end
        S_WAIT_REPLY: begin
          if (!r_resolving) begin
            r_state <= S_IDLE;
          end else if (r_reply_pend) begin
            // Timer is left untouched so the reply detour does not extend or shorten the window.
            r_state       <= S_SEND;
            r_arp_tx_en   <= 1'b1;
            r_arp_tx_type <= 1'b1;
            r_des_mac     <= w_rep_mac;
            r_des_ip      <= w_rep_ip;
          end else if (r_timer == 32'(TIMEOUT_CYC - 1)) begin
`ifdef ARP_RETRY_EN
            if (r_retry_cnt < 32'(RETRY_MAX)) begin
              r_retry_cnt   <= r_retry_cnt + 32'd1;
              r_state       <= S_SEND;
              r_arp_tx_en   <= 1'b1;
              r_arp_tx_type <= 1'b0;
              r_des_mac     <= '1;
              r_des_ip      <= DES_IP;
            end else begin
              r_resolve_fail <= 1'b1;
              r_resolving    <= 1'b0;
              r_retry_cnt    <= '0;
              r_state        <= S_IDLE;
            end
`else
            r_resolving <= 1'b0;
            r_state     <= S_IDLE;
`endif
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Captures come last so a fresh event overrides any clear issued by the FSM this cycle.
      if (w_req_rx) begin
        r_rep_mac    <= arp.src_mac;
        r_rep_ip     <= arp.src_ip;
        r_reply_pend <= 1'b1;
      end
      if (w_peer_match) begin
        r_peer_mac   <= arp.src_mac;
        r_peer_ip    <= arp.src_ip;
        r_peer_valid <= 1'b1;
        r_resolving  <= 1'b0;
      end
      if (arp.arp_req && !r_resolving && (r_state == S_IDLE || r_state == S_WAIT_DONE))
        r_req_pend <= 1'b1;
    end
  end

  assign arp.arp_tx_en   = r_arp_tx_en;
  assign arp.arp_tx_type = r_arp_tx_type;
  assign arp.des_mac     = r_des_mac;
  assign arp.des_ip      = r_des_ip;
  assign arp.peer_valid  = r_peer_valid;
  assign arp.peer_mac    = r_peer_mac;
  assign arp.peer_ip     = r_peer_ip;
  assign arp.arp_busy    = (r_state != S_IDLE);
`ifdef ARP_RETRY_EN
  assign arp.resolve_fail = r_resolve_fail;
`endif

endmodule

// File: tb/tb_eth_arp_ctrl.sv
// Directed bench for eth_arp_ctrl with TIMEOUT_CYC=100, RETRY_MAX=2; covers both ARP_RETRY_EN builds.
module tb_eth_arp_ctrl;
  localparam logic [31:0] PEER_IP = 32'hC0A80166;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   tx_cnt = 0;
  int   base_cnt;
  logic prev_en = 1'b0;

  eth_arp_ctrl_if ifc ();

  eth_arp_ctrl #(
    .DES_IP      (PEER_IP),
    .TIMEOUT_CYC (100),
    .RETRY_MAX   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arp (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every launch pulse is counted and must never be followed by another in the next cycle.
  always @(negedge clk) begin
    if (ifc.arp_tx_en) begin
      tx_cnt++;
      check("tx_en_back_to_back", {63'd0, prev_en}, 64'd0);
    end
    prev_en = ifc.arp_tx_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_pkt(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    ifc.arp_rx_done = 1'b1;
    ifc.arp_rx_type = typ;
    ifc.src_mac     = mac;
    ifc.src_ip      = ip;
    tick();
    ifc.arp_rx_done = 1'b0;
  endtask

  task automatic pulse_req();
    ifc.arp_req = 1'b1;
    tick();
    ifc.arp_req = 1'b0;
  endtask

  task automatic pulse_txdone();
    ifc.tx_done = 1'b1;
    tick();
    ifc.tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_en"},   {63'd0, ifc.arp_tx_en}, 64'd0);
    check({tag, "_tx_type"}, {63'd0, ifc.arp_tx_type}, 64'd0);
    check({tag, "_des_mac"}, {16'd0, ifc.des_mac}, 64'd0);
    check({tag, "_des_ip"},  {32'd0, ifc.des_ip}, 64'd0);
    check({tag, "_pvalid"},  {63'd0, ifc.peer_valid}, 64'd0);
    check({tag, "_pmac"},    {16'd0, ifc.peer_mac}, 64'd0);
    check({tag, "_pip"},     {32'd0, ifc.peer_ip}, 64'd0);
    check({tag, "_busy"},    {63'd0, ifc.arp_busy}, 64'd0);
`ifdef ARP_RETRY_EN
    check({tag, "_fail"},    {63'd0, ifc.resolve_fail}, 64'd0);
`endif
  endtask

  initial begin
    ifc.arp_rx_done = 1'b0;
    ifc.arp_rx_type = 1'b0;
    ifc.src_mac     = '0;
    ifc.src_ip      = '0;
    ifc.arp_req     = 1'b0;
    ifc.tx_done     = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);

    // Received request answered two cycles later and held until tx_done.
    rx_pkt(1'b0, 48'h112233445566, PEER_IP);
    check("rq_n1_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    tick();
    check("rq_n2_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("rq_type", {63'd0, ifc.arp_tx_type}, 64'd1);
    check("rq_des_mac", {16'd0, ifc.des_mac}, 64'h112233445566);
    check("rq_des_ip", {32'd0, ifc.des_ip}, 64'hC0A80166);
    check("rq_busy", {63'd0, ifc.arp_busy}, 64'd1);
    repeat (4) tick();
    check("rq_hold_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    check("rq_hold_mac", {16'd0, ifc.des_mac}, 64'h112233445566);
    check("rq_hold_type", {63'd0, ifc.arp_tx_type}, 64'd1);
    pulse_txdone();
    check("rq_done_busy", {63'd0, ifc.arp_busy}, 64'd0);
    pulse_txdone();
    tick();
    check("stray_txdone_busy", {63'd0, ifc.arp_busy}, 64'd0);
    check("stray_txdone_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);

    // Resolve: broadcast request, foreign reply ignored, matching reply cached.
    pulse_req();
    tick();
    check("res_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("res_type", {63'd0, ifc.arp_tx_type}, 64'd0);
    check("res_des_mac", {16'd0, ifc.des_mac}, {16'd0, BCAST});
    check("res_des_ip", {32'd0, ifc.des_ip}, 64'hC0A80166);
    repeat (2) tick();
    pulse_txdone();
    repeat (5) tick();
    rx_pkt(1'b1, 48'h010203040506, 32'hC0A80199);
    check("foreign_pvalid", {63'd0, ifc.peer_valid}, 64'd0);
    check("foreign_busy", {63'd0, ifc.arp_busy}, 64'd1);
    tick();
    rx_pkt(1'b1, 48'hAABBCCDDEEFF, PEER_IP);
    check("peer_valid", {63'd0, ifc.peer_valid}, 64'd1);
    check("peer_mac", {16'd0, ifc.peer_mac}, 64'hAABBCCDDEEFF);
    check("peer_ip", {32'd0, ifc.peer_ip}, 64'hC0A80166);
    check("peer_busy_n1", {63'd0, ifc.arp_busy}, 64'd1);
    tick();
    check("peer_busy_n2", {63'd0, ifc.arp_busy}, 64'd0);

    // Request during WAIT_REPLY: 10 counted cycles before the detour, 90 after, timeout at M+110.
    pulse_req();
    repeat (2) tick();
    pulse_txdone();
    repeat (9) tick();
    rx_pkt(1'b0, 48'h0A1B2C3D4E5F, 32'hC0A80177);
    tick();
    check("frz_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("frz_type", {63'd0, ifc.arp_tx_type}, 64'd1);
    check("frz_des_mac", {16'd0, ifc.des_mac}, 64'h0A1B2C3D4E5F);
    check("frz_des_ip", {32'd0, ifc.des_ip}, 64'hC0A80177);
    repeat (8) tick();
    pulse_txdone();
    repeat (89) tick();
    check("frz_m110_busy", {63'd0, ifc.arp_busy}, 64'd1);
    check("frz_m110_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    tick();
`ifdef ARP_RETRY_EN
    check("frz_retry_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("frz_retry_type", {63'd0, ifc.arp_tx_type}, 64'd0);
    tick();
`else
    check("frz_timeout_busy", {63'd0, ifc.arp_busy}, 64'd0);
    check("frz_timeout_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    pulse_req();
    repeat (2) tick();
`endif

    // Asynchronous reset in WAIT_DONE clears everything at once, including the cache.
    check("rst_pre_busy", {63'd0, ifc.arp_busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    end
    check("post_rst_busy", {63'd0, ifc.arp_busy}, 64'd0);

    // Simultaneous arp_req and received request: reply first, then the broadcast request.
    ifc.arp_req = 1'b1;
    rx_pkt(1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80105);
    ifc.arp_req = 1'b0;
    tick();
    check("sim_first_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("sim_first_type", {63'd0, ifc.arp_tx_type}, 64'd1);
    check("sim_first_ip", {32'd0, ifc.des_ip}, 64'hC0A80105);
    repeat (2) tick();
    pulse_txdone();
    check("sim_gap_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
    tick();
    check("sim_second_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    check("sim_second_type", {63'd0, ifc.arp_tx_type}, 64'd0);
    check("sim_second_mac", {16'd0, ifc.des_mac}, {16'd0, BCAST});
    tick();
    pulse_txdone();
    tick();
    rx_pkt(1'b1, 48'h665544332211, PEER_IP);
    check("sim_peer_mac", {16'd0, ifc.peer_mac}, 64'h665544332211);
    tick();
    check("sim_end_busy", {63'd0, ifc.arp_busy}, 64'd0);

    // No reply at all: window of 100 WAIT_REPLY cycles after each tx_done.
    base_cnt = tx_cnt;
    pulse_req();
    tick();
    check("nr_first_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
    repeat (2) tick();
    pulse_txdone();
`ifdef ARP_RETRY_EN
    for (int r = 0; r < 2; r++) begin
      repeat (99) tick();
      check("nr_t100_tx_en", {63'd0, ifc.arp_tx_en}, 64'd0);
      tick();
      check("nr_retry_tx_en", {63'd0, ifc.arp_tx_en}, 64'd1);
      check("nr_retry_type", {63'd0, ifc.arp_tx_type}, 64'd0);
      repeat (2) tick();
      pulse_txdone();
    end
    repeat (99) tick();
    check("nr_fail_early", {63'd0, ifc.resolve_fail}, 64'd0);
    check("nr_busy_early", {63'd0, ifc.arp_busy}, 64'd1);
    tick();
    check("nr_fail_pulse", {63'd0, ifc.resolve_fail}, 64'd1);
    check("nr_busy_after", {63'd0, ifc.arp_busy}, 64'd0);
    tick();
    check("nr_fail_end", {63'd0, ifc.resolve_fail}, 64'd0);
    tick();
    check("nr_req_pulses", 64'(tx_cnt - base_cnt), 64'd3);
`else
    repeat (99) tick();
    check("nr_busy_early", {63'd0, ifc.arp_busy}, 64'd1);
    tick();
    check("nr_busy_after", {63'd0, ifc.arp_busy}, 64'd0);
    repeat (2) tick();
    check("nr_req_pulses", 64'(tx_cnt - base_cnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
